chip8_draw_engine: RTL



---
 rtl/chip8_pkg.sv | 21 ++
 rtl/chip8_sprite_mask.sv | 35 +++
 rtl/chip8_draw_engine.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// chip8_pkg
// Shared constants and FSM encoding for the Chip-8 display datapath.
//   SCREEN_W / SCREEN_H : video memory geometry (64 columns x 32 rows)
//   SPRITE_W            : pixels per sprite byte
//   draw_state_e        : draw engine FSM states
package chip8_pkg;

    localparam int SCREEN_W = 64;
    localparam int SCREEN_H = 32;
    localparam int SPRITE_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        WAIT  = 3'd3,
        RMW   = 3'd4,
        DONE  = 3'd5
    } draw_state_e;

endpackage

// File: rtl/chip8_sprite_mask.sv
// chip8_sprite_mask
// Combinational expansion of one sprite byte into a 64-pixel row mask.
// Sprite bit 7 lands on column x_i, bit 0 on column x_i+7. With WRAP_X set
// the columns wrap mod 64; otherwise columns past 63 are dropped.
// Ports:
//   sprite_i [7:0]  sprite byte
//   x_i      [5:0]  start column
//   mask_o   [0:63] row mask, bit c = column c
module chip8_sprite_mask
    import chip8_pkg::*;
#(
    parameter int WRAP_X = 1
) (
    input  logic [7:0]          sprite_i,
    input  logic [5:0]          x_i,
    output logic [0:SCREEN_W-1] mask_o
);

    // Each column asks: how far am I to the right of x (mod 64)? If that
    // distance is within the sprite width, it takes the matching sprite bit.
    // A column to the left of x only qualifies through wrap-around.
    genvar gi;
    generate
        for (gi = 0; gi < SCREEN_W; gi++) begin : g_col
            logic [5:0] off;
            logic       in_span;
            logic       no_wrap_ok;
            assign off        = 6'(gi) - x_i;
            assign in_span    = (off < 6'(SPRITE_W));
            assign no_wrap_ok = (WRAP_X != 0) || (6'(gi) >= x_i);
            assign mask_o[gi] = in_span && no_wrap_ok && sprite_i[3'd7 - off[2:0]];
        end
    endgenerate

endmodule

// File: rtl/chip8_draw_engine.sv
// chip8_draw_engine
// Sequences 00E0 (clear screen) and DXYN (draw sprite) against a 64x32 video
// memory that is read combinationally and written one 64-pixel row at a time.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start_draw, start_clear    one-cycle operation requests (ignored while busy)
//   x, y, n, i_addr            draw operands, latched on acceptance
//   mem_addr, mem_rd, mem_data sprite byte fetch; data arrives MEM_LATENCY later
//   vid_addr, vid_rdata        row index and current row contents
//   vid_we, vid_wdata          row write strobe and new row contents
//   busy, done, collision      status; collision is VF, valid from done
module chip8_draw_engine
    import chip8_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int WRAP_X      = 1,
    parameter int WRAP_Y      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_draw,
    input  logic                start_clear,
    input  logic [5:0]          x,
    input  logic [4:0]          y,
    input  logic [3:0]          n,
    input  logic [11:0]         i_addr,
    output logic [11:0]         mem_addr,
    output logic                mem_rd,
    input  logic [7:0]          mem_data,
    output logic [4:0]          vid_addr,
    input  logic [0:SCREEN_W-1] vid_rdata,
    output logic                vid_we,
    output logic [0:SCREEN_W-1] vid_wdata,
    output logic                busy,
    output logic                done,
    output logic                collision
);

    localparam logic [1:0] WAIT_LAST = 2'(MEM_LATENCY - 1);

    draw_state_e state_q, state_d;
    logic [5:0]  x_q, x_d;
    logic [4:0]  y_q, y_d;
    logic [3:0]  n_q, n_d;
    logic [11:0] i_q, i_d;
    logic [4:0]  row_q, row_d;
    logic [1:0]  wait_q, wait_d;
    logic [7:0]  sprite_q, sprite_d;
    logic        coll_q, coll_d;

    logic [0:SCREEN_W-1] mask;
    logic [4:0]          row_inc;
    logic [5:0]          y_sum;

    chip8_sprite_mask #(
        .WRAP_X (WRAP_X)
    ) u_mask (
        .sprite_i (sprite_q),
        .x_i      (x_q),
        .mask_o   (mask)
    );

    assign row_inc = row_q + 5'd1;
    // Six bits so that running off the bottom of the screen is visible.
    assign y_sum   = {1'b0, y_q} + {1'b0, row_inc};

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        n_d       = n_q;
        i_d       = i_q;
        row_d     = row_q;
        wait_d    = wait_q;
        sprite_d  = sprite_q;
        coll_d    = coll_q;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        vid_we    = 1'b0;
        vid_addr  = '0;
        vid_wdata = '0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_clear || start_draw) begin
                    x_d    = x;
                    y_d    = y;
                    n_d    = n;
                    i_d    = i_addr;
                    row_d  = '0;
                    coll_d = 1'b0;
                end
                // Clear has priority; a simultaneous draw is simply dropped.
                if (start_clear) begin
                    state_d = CLEAR;
                end else if (start_draw) begin
                    state_d = (n == 4'd0) ? DONE : FETCH;
                end
            end

            CLEAR: begin
                vid_we   = 1'b1;
                vid_addr = row_q;
                row_d    = row_inc;
                if (row_q == 5'(SCREEN_H - 1)) begin
                    state_d = DONE;
                end
            end

            FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = i_q + 12'(row_q);
                wait_d   = '0;
                state_d  = WAIT;
            end

            WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    sprite_d = mem_data;
                    state_d  = RMW;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end

            RMW: begin
                vid_we    = 1'b1;
                vid_addr  = y_q + row_q;
                vid_wdata = vid_rdata ^ mask;
                coll_d    = coll_q | (|(vid_rdata & mask));
                row_d     = row_inc;
                // Without vertical wrap, the draw stops at the bottom edge
                // rather than fetching bytes for rows that would be clipped.
                if ((row_inc == {1'b0, n_q}) ||
                    ((WRAP_Y == 0) && (y_sum > 6'(SCREEN_H - 1)))) begin
                    state_d = DONE;
                end else begin
                    state_d = FETCH;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            n_q      <= '0;
            i_q      <= '0;
            row_q    <= '0;
            wait_q   <= '0;
            sprite_q <= '0;
            coll_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            n_q      <= n_d;
            i_q      <= i_d;
            row_q    <= row_d;
            wait_q   <= wait_d;
            sprite_q <= sprite_d;
            coll_q   <= coll_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign collision = coll_q;

endmodule
